// File: rtl/compare_scheduler_pkg.sv
// Shared encodings for the compare scheduler: operand width, condition
// select codes, the reserved select code and the scheduler FSM states.
package compare_scheduler_pkg;

    // Operand width of the shared comparer.
    localparam int DATA_W = 32;

    // Condition select encodings driven on reqN_sel.
    typedef enum logic [2:0] {
        SEL_NE   = 3'd0,
        SEL_LT   = 3'd1,
        SEL_LE   = 3'd2,
        SEL_EQ   = 3'd3,
        SEL_GE   = 3'd4,
        SEL_GT   = 3'd5,
        SEL_TRUE = 3'd6,
        SEL_RSVD = 3'd7
    } sel_e;

    // Select code that yields result 0 and raises the error flag.
    localparam logic [2:0] SEL_RESERVED = 3'd7;

    // Scheduler states: wait for a request, run the comparer, hold the response.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Round-robin pick between two requesters. Returns the requester id to
    // grant; only meaningful when at least one valid is high. On a tie the
    // requester that was not served last wins.
    function automatic logic pick_grant(input logic v0, input logic v1,
                                        input logic last_served);
        logic id;
        if (v0 && v1) begin
            id = ~last_served;
        end else begin
            id = v1;
        end
        return id;
    endfunction

endpackage

// File: rtl/compare_scheduler_selective_comparer.sv
// Purely combinational 32-bit selective comparer shared by both requesters.
// Produces a 1-bit condition result and flags the reserved select code.
module SelectiveComparer
    import compare_scheduler_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    input  logic [2:0]  sel,
    output logic        result,
    output logic        err
);

    logic lt;
    logic eq;

    // Base relations: less-than honours signedness, equality does not care.
    always_comb begin
        if (is_signed) begin
            lt = ($signed(a) < $signed(b));
        end else begin
            lt = (a < b);
        end
        eq = (a == b);
    end

    // Derive the selected condition from the base relations.
    always_comb begin
        result = 1'b0;
        err    = 1'b0;
        case (sel)
            SEL_NE:   result = ~eq;
            SEL_LT:   result = lt;
            SEL_LE:   result = lt | eq;
            SEL_EQ:   result = eq;
            SEL_GE:   result = ~lt;
            SEL_GT:   result = ~(lt | eq);
            SEL_TRUE: result = 1'b1;
            default: begin
                result = 1'b0;
                err    = (sel == SEL_RESERVED);
            end
        endcase
    end

endmodule

// File: rtl/compare_scheduler.sv
// Two-requester scheduler around a single shared selective comparer.
// Requests are granted round-robin in IDLE, operands are registered, the
// comparer runs for one cycle in EXEC, and the result is held in RESP until
// the owning requester consumes it.
module compare_scheduler
    import compare_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_signed,
    input  logic [2:0]  req0_sel,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_signed,
    input  logic [2:0]  req1_sel,

    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [31:0] resp0_result,
    output logic        resp0_err,

    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp1_result,
    output logic        resp1_err,

    output logic        busy
);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic        result_q, result_d;
    logic        err_q, err_d;

    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        signed_q, signed_d;
    logic [2:0]  sel_q, sel_d;

    logic        grant_any;
    logic        grant_id;
    logic        owner_ack;
    logic        cmp_result;
    logic        cmp_err;

    // The comparer only ever sees registered operands, so requester inputs
    // may change freely once the handshake has happened.
    SelectiveComparer u_cmp (
        .a         (a_q),
        .b         (b_q),
        .is_signed (signed_q),
        .sel       (sel_q),
        .result    (cmp_result),
        .err       (cmp_err)
    );

    // Arbitration: who would be granted if the scheduler were idle.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = pick_grant(req0_valid, req1_valid, last_q);
        owner_ack = owner_q ? resp1_ready : resp0_ready;
    end

    // Next-state and handshake outputs. Readies are also gated by reset so
    // nothing is offered to the requesters while reset is held low.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        result_d    = result_q;
        err_d       = err_q;
        a_d         = a_q;
        b_d         = b_q;
        signed_d    = signed_q;
        sel_d       = sel_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (reset && grant_any) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    owner_d    = grant_id;
                    last_d     = grant_id;
                    if (grant_id) begin
                        a_d      = req1_a;
                        b_d      = req1_b;
                        signed_d = req1_signed;
                        sel_d    = req1_sel;
                    end else begin
                        a_d      = req0_a;
                        b_d      = req0_b;
                        signed_d = req0_signed;
                        sel_d    = req0_sel;
                    end
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = cmp_result;
                err_d    = cmp_err;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                resp0_valid = ~owner_q;
                resp1_valid = owner_q;
                if (owner_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Response data is steered to the owner only; the other side reads zero.
    always_comb begin
        resp0_result = {31'd0, result_q & ~owner_q};
        resp1_result = {31'd0, result_q &  owner_q};
        resp0_err    = err_q & ~owner_q;
        resp1_err    = err_q &  owner_q;
        busy         = (state_q != ST_IDLE);
    end

    // Control state: reset returns to IDLE, drops any in-flight compare and
    // lets requester 0 win the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            result_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Operand registers: only loaded on a handshake, no reset needed.
    always_ff @(posedge clk) begin
        a_q      <= a_d;
        b_q      <= b_d;
        signed_q <= signed_d;
        sel_q    <= sel_d;
    end

endmodule
